sseg_decoder: RTL

- Receiving end of the multiplexed seven-segment display interface: watches the `sseg`/`an` pins driven by the display controller and reconstructs the 4-digit decimal number shown.
- Filters and captures each digit while it is strobed, decodes segment patterns to BCD, then converts the BCD frame to binary sequentially.
- Used as an on-chip loopback monitor of the frequency-meter display and as a bench checker.

---
 rtl/sseg_decoder_if.sv | 15 +
 rtl/sseg_decoder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sseg_decoder_if.sv
// Bundle between a multiplexed seven-segment display driver and the
// decoder that watches its pins. The driver side owns sseg/an; the decoder
// side returns the reconstructed number.
interface sseg_decoder_if #(
  parameter int OUT_WIDTH = 32
);
  logic [6:0]           sseg;
  logic [3:0]           an;
  logic [OUT_WIDTH-1:0] value;
  logic                 valid;
  logic                 err;

  modport master (output sseg, an, input value, valid, err);
  modport slave  (input sseg, an, output value, valid, err);
endinterface

// File: rtl/sseg_decoder.sv
// Seven-segment display monitor: synchronises the display pins, captures each
// strobed digit once it has been stable long enough, decodes the glyph to BCD,
// then converts a complete 4-digit frame to binary with a multiply-by-ten loop.
module sseg_decoder #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int OUT_WIDTH     = 32
) (
  input  logic          clk,
  input  logic          rst,
  sseg_decoder_if.slave bus
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_PRE = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, DONE = 2'd2} state_t;

  // Active-low glyph {g..a} to {bad, bcd}; anything non-decimal is bad digit 0.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    logic [4:0] res;
    case (seg)
      7'b1000000: res = {1'b0, 4'd0};
      7'b1111001: res = {1'b0, 4'd1};
      7'b0100100: res = {1'b0, 4'd2};
      7'b0110000: res = {1'b0, 4'd3};
      7'b0011001: res = {1'b0, 4'd4};
      7'b0010010: res = {1'b0, 4'd5};
      7'b0000010: res = {1'b0, 4'd6};
      7'b1111000: res = {1'b0, 4'd7};
      7'b0000000: res = {1'b0, 4'd8};
      7'b0010000: res = {1'b0, 4'd9};
      default:    res = {1'b1, 4'd0};
    endcase
    return res;
  endfunction

  // True when exactly one active-low enable is asserted.
  function automatic logic one_low(input logic [3:0] an_v);
    logic [3:0] act;
    act = ~an_v;
    return (act != 4'd0) && ((act & (act - 4'd1)) == 4'd0);
  endfunction

  logic [6:0]    sseg_sync_r [SYNC_STAGES];
  logic [3:0]    an_sync_r   [SYNC_STAGES];
  logic [6:0]    sseg_s, sseg_prev_r;
  logic [3:0]    an_s, an_prev_r;
  logic          change_s, capture_s, captured_r;
  logic [CW-1:0] cnt_r;
  logic [1:0]    pos_s;
  logic [4:0]    dec_s;
  logic [3:0]    digit_r  [4];
  logic [3:0]    shadow_r [4];
  logic [3:0]    bad_r, shadow_bad_r, mask_r, mask_next_s;
  state_t        state_r, state_next_s;
  logic          launch_s, last_s;
  logic [1:0]    step_r;
  logic [13:0]   acc_r, acc_next_s;
  logic [OUT_WIDTH-1:0] value_r;
  logic          valid_r, err_r;

  assign sseg_s = sseg_sync_r[SYNC_STAGES-1];
  assign an_s   = an_sync_r[SYNC_STAGES-1];

  // Input synchroniser chain; resets to the blank (all off) pattern.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sseg_sync_r[i] <= 7'h7f;
        an_sync_r[i]   <= 4'hf;
      end
    end else begin
      sseg_sync_r[0] <= bus.sseg;
      an_sync_r[0]   <= bus.an;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sseg_sync_r[i] <= sseg_sync_r[i-1];
        an_sync_r[i]   <= an_sync_r[i-1];
      end
    end
  end

  // Change detection, digit position and glyph decode of the current sample.
  always_comb begin
    change_s  = (an_s != an_prev_r) || (sseg_s != sseg_prev_r);
    dec_s     = seg_decode(sseg_s);
    capture_s = 1'b0;
    if (!change_s && !captured_r && (cnt_r == CNT_PRE) && one_low(an_s)) begin
      capture_s = 1'b1;
    end else begin
      capture_s = 1'b0;
    end
    case (an_s)
      4'b1110: pos_s = 2'd0;
      4'b1101: pos_s = 2'd1;
      4'b1011: pos_s = 2'd2;
      4'b0111: pos_s = 2'd3;
      default: pos_s = 2'd0;
    endcase
  end

  // Dwell tracking: stability counter and one-capture-per-dwell flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sseg_prev_r <= 7'h7f;
      an_prev_r   <= 4'hf;
      cnt_r       <= '0;
      captured_r  <= 1'b0;
    end else begin
      sseg_prev_r <= sseg_s;
      an_prev_r   <= an_s;
      if (change_s) begin
        cnt_r      <= '0;
        captured_r <= 1'b0;
      end else begin
        cnt_r      <= (cnt_r == CNT_MAX) ? cnt_r : cnt_r + 1'b1;
        captured_r <= captured_r | capture_s;
      end
    end
  end

  // Next captured-position mask: a launch clears it, a capture adds its bit.
  always_comb begin
    mask_next_s = launch_s ? 4'b0000 : mask_r;
    if (capture_s) begin
      mask_next_s = mask_next_s | (4'b0001 << pos_s);
    end else begin
      mask_next_s = mask_next_s;
    end
  end

  // Captured digit storage; recapturing a position overwrites it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) digit_r[i] <= 4'd0;
      bad_r  <= 4'b0000;
      mask_r <= 4'b0000;
    end else begin
      mask_r <= mask_next_s;
      if (capture_s) begin
        digit_r[pos_s] <= dec_s[3:0];
        bad_r[pos_s]   <= dec_s[4];
      end
    end
  end

  // Conversion FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_next_s;
  end

  // Conversion FSM next state: launch on a full mask, four steps, one done cycle.
  always_comb begin
    state_next_s = state_r;
    launch_s     = 1'b0;
    last_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (mask_r == 4'b1111) begin
          launch_s     = 1'b1;
          state_next_s = CONV;
        end else begin
          state_next_s = IDLE;
        end
      end
      CONV: begin
        if (step_r == 2'd0) begin
          last_s       = 1'b1;
          state_next_s = DONE;
        end else begin
          state_next_s = CONV;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  assign acc_next_s = (acc_r << 3) + (acc_r << 1) + {10'd0, shadow_r[step_r]};

  // BCD-to-binary datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) shadow_r[i] <= 4'd0;
      shadow_bad_r <= 4'b0000;
      acc_r        <= 14'd0;
      step_r       <= 2'd3;
      value_r      <= '0;
      valid_r      <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      valid_r <= last_s;
      err_r   <= last_s & (|shadow_bad_r);
      if (last_s && !(|shadow_bad_r)) value_r <= OUT_WIDTH'(acc_next_s);
      if (launch_s) begin
        shadow_r     <= digit_r;
        shadow_bad_r <= bad_r;
        acc_r        <= 14'd0;
        step_r       <= 2'd3;
      end else if (state_r == CONV) begin
        acc_r  <= acc_next_s;
        step_r <= step_r - 2'd1;
      end
    end
  end

  assign bus.value = value_r;
  assign bus.valid = valid_r;
  assign bus.err   = err_r;

endmodule
